// File: rtl/uart_tx_slave_if.sv
// Bus port bundle for the memory-mapped UART transmitter.
// The core is the initiator (master); the UART is the responder (slave).
interface uart_tx_slave_if;
    logic [31:0] busaddr;
    logic [31:0] buswdata;
    logic        buswrite;
    logic [31:0] busrdata;

    modport master (output busaddr, output buswdata, output buswrite, input busrdata);
    modport slave  (input busaddr, input buswdata, input buswrite, output busrdata);
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter: a byte FIFO drained by an 8N1 serialiser.
// Optional feature macro UART_TX_PARITY_EN adds an even-parity bit (8E1).
// Register map on busaddr[3:2]: 0 DATA(w), 1 STATUS, 2 DIV, 3 reserved.
module uart_tx_slave #(
    parameter int          DEPTH  = 8,
    parameter logic [15:0] DIVRST = 16'd434
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_tx_slave_if.slave  bus,
    output logic            txd_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic         par_q, par_d;
`endif
    logic [15:0]  div_q;
    logic [7:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic         ovf_q;

    logic [1:0]   sel;
    logic         wr_data, wr_stat, wr_div, push_ok, pop, full, empty, busy;
    logic [7:0]   head;
    logic [15:0]  reload;
    logic         unused_ok;

    assign sel     = bus.busaddr[3:2];
    assign wr_data = bus.buswrite && (sel == 2'd0);
    assign wr_stat = bus.buswrite && (sel == 2'd1);
    assign wr_div  = bus.buswrite && (sel == 2'd2);
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = wr_data && !full;
    assign head    = mem_q[rptr_q];
    assign busy    = (state_q != S_IDLE);
    assign reload  = div_q - 16'd1;
    assign unused_ok = &{1'b0, bus.busaddr[31:4], bus.busaddr[1:0], bus.buswdata[31:16]};

    // Occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset, pointers qualify them.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= bus.buswdata[7:0];
    end

    // FIFO pointers, count, sticky overflow and the baud divisor register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIVRST;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            if (wr_data && full)                     ovf_q <= 1'b1;
            else if (wr_stat && bus.buswdata[3])     ovf_q <= 1'b0;
            // A zero divisor would never reach a bit boundary; clamp to 1.
            if (wr_div) div_q <= (bus.buswdata[15:0] == 16'd0) ? 16'd1 : bus.buswdata[15:0];
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serialiser next state and txd; DIV is re-sampled at every bit reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop     = 1'b0;
        txd_o   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    cnt_d   = reload;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd_o = 1'b0;
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else cnt_d = cnt_q - 16'd1;
            end
            S_DATA: begin
                txd_o = shift_q[0];
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else bit_d = bit_q + 3'd1;
                end else cnt_d = cnt_q - 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_o = par_q;
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload;
                    state_d = S_STOP;
                end else cnt_d = cnt_q - 16'd1;
            end
`endif
            S_STOP: begin
                txd_o = 1'b1;
                if (cnt_q == 16'd0) begin
                    // Back-to-back: next start bit follows the stop bit directly.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        cnt_d   = reload;
                        state_d = S_START;
                    end else state_d = S_IDLE;
                end else cnt_d = cnt_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux, combinational from the decoded address.
    always_comb begin
        bus.busrdata = 32'd0;
        case (sel)
            2'd1:    bus.busrdata = {16'd0, 8'(count_q), 3'd0, PAR_EN, ovf_q, empty, full, busy};
            2'd2:    bus.busrdata = {16'd0, div_q};
            default: bus.busrdata = {31'd0, unused_ok};
        endcase
    end
endmodule
